// File: rtl/mem_access_unit_pkg.sv
// Shared access-size codes, FSM encoding, timeout limit and bus payload for the
// load/store memory access unit.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned BE_W           = DATA_W / 8;
    localparam int unsigned TIMEOUT_CYCLES = 256;
    localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Unused funct3 codes fall through to word size.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lo[0];
            default: return (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input size_t sz, input logic [DATA_W-1:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        case (access_size(funct3))
            SZ_BYTE: data = funct3[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: data = funct3[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: aligns core requests onto a word-wide memory bus,
// stalls the core until ack, and reports misalignment and ack timeouts.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BE_W-1:0]   m_be,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    mem_cmd_t          cmd;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] load_data;
    size_t             req_size;
    logic              req_any;
    logic              req_aligned;
    logic              accept;

    assign req_size    = access_size(funct3);
    assign req_any     = mem_read | mem_write;
    assign req_aligned = is_aligned(req_size, addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the same-cycle stall/misaligned handshake to the core.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    if (req_aligned) begin
                        stall     = 1'b1;
                        accept    = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (m_ack)                                 state_nxt = ST_DONE;
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_nxt = ST_ERR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    load_formatter u_load_formatter (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (m_rdata),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cmd       <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            rdata     <= '0;
            m_req     <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            m_req     <= (state_nxt == ST_REQ);
            bus_error <= (state_nxt == ST_ERR);

            if (state == ST_REQ && state_nxt == ST_REQ) cnt <= cnt + CNT_W'(1);
            else                                        cnt <= '0;

            // mem_write wins when both strobes are high.
            if (accept) begin
                cmd.we    <= mem_write;
                cmd.addr  <= {addr[ADDR_W-1:2], 2'b00};
                cmd.be    <= byte_enables(req_size, addr[1:0]);
                cmd.wdata <= lane_data(req_size, wdata);
                funct3_q  <= funct3;
                addr_lo_q <= addr[1:0];
            end

            if (state == ST_REQ) begin
                if (m_ack)                     rdata <= cmd.we ? '0 : load_data;
                else if (state_nxt == ST_ERR)  rdata <= '0;
            end
        end
    end

    assign m_we    = cmd.we;
    assign m_addr  = cmd.addr;
    assign m_be    = cmd.be;
    assign m_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized
// transactions against a byte-level reference model, and timeout/reset sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          ack_dly;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                                input int dly, input logic mis, input logic [3:0] be,
                                input logic [31:0] mwd, input logic [31:0] rdv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.mword = mw;
        v.ack_dly = dly; v.exp_mis = mis; v.exp_be = be; v.exp_mwdata = mwd; v.exp_rdata = rdv;
        return v;
    endfunction

    // Byte-level model: size in bytes, offset in word, bytes gathered and extended arithmetically.
    function automatic vec_t ref_model(input vec_t vin);
        vec_t   v;
        int     n;
        int     off;
        longint val;
        v   = vin;
        n   = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(v.addr % 32'd4);
        v.exp_mis    = (off % n) != 0;
        v.exp_be     = '0;
        v.exp_mwdata = '0;
        val          = 0;
        for (int k = 0; k < 4; k++) v.exp_mwdata[8*k +: 8] = v.wdata[8*(k % n) +: 8];
        if (!v.exp_mis) begin
            for (int i = 0; i < n; i++) begin
                v.exp_be[off+i] = 1'b1;
                val += longint'(v.mword[8*(off+i) +: 8]) << (8*i);
            end
        end
        if (!v.f3[2] && n < 4 && val >= (longint'(1) << (8*n - 1))) val -= (longint'(1) << (8*n));
        v.exp_rdata = v.wr ? 32'h0 : val[31:0];
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        m_ack = 1'b0; m_rdata = $urandom;
        #1;
        check({tag, ".misaligned"}, 32'(misaligned), 32'(v.exp_mis));
        check({tag, ".stall_T"}, 32'(stall), 32'(!v.exp_mis));
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
        #1;
        if (v.exp_mis) begin
            check({tag, ".no_req"}, 32'(m_req), 32'd0);
            check({tag, ".mis_pulse_end"}, 32'(misaligned), 32'd0);
            check({tag, ".no_stall"}, 32'(stall), 32'd0);
            return;
        end
        check({tag, ".m_req"}, 32'(m_req), 32'd1);
        check({tag, ".stall_T1"}, 32'(stall), 32'd1);
        check({tag, ".m_we"}, 32'(m_we), 32'(v.wr));
        check({tag, ".m_addr"}, m_addr, v.addr & 32'hFFFF_FFFC);
        check({tag, ".m_be"}, 32'(m_be), 32'(v.exp_be));
        if (v.wr) check({tag, ".m_wdata"}, m_wdata, v.exp_mwdata);
        for (int i = 0; i < v.ack_dly; i++) begin
            @(negedge clk); #1;
            check({tag, ".m_req_hold"}, 32'(m_req), 32'd1);
        end
        m_ack = 1'b1; m_rdata = v.mword;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = $urandom;
        #1;
        check({tag, ".done_stall"}, 32'(stall), 32'd0);
        check({tag, ".done_m_req"}, 32'(m_req), 32'd0);
        check({tag, ".rdata"}, rdata, v.exp_rdata);
    endtask

    vec_t dir[14];
    vec_t rv;
    int   n_req;

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0;
        wdata = '0; m_rdata = '0; m_ack = 1'b0;

        dir[0]  = mk(1, 0, 3'b010, 32'h100, 32'h1111_1111, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        dir[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,         32'h8000_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        dir[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,         32'h8000_0000, 1, 0, 4'b1000, 32'h0, 32'h0000_0080);
        dir[3]  = mk(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 2, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        dir[4]  = mk(1, 0, 3'b010, 32'h101, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0, 32'h0);
        dir[5]  = mk(1, 0, 3'b001, 32'h102, 32'h0,         32'h8765_4321, 1, 0, 4'b1100, 32'h0, 32'hFFFF_8765);
        dir[6]  = mk(1, 0, 3'b101, 32'h100, 32'h0,         32'h0000_F00D, 0, 0, 4'b0011, 32'h0, 32'h0000_F00D);
        dir[7]  = mk(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        dir[8]  = mk(1, 1, 3'b010, 32'h404, 32'hCAFE_F00D, 32'h1234_5678, 3, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        dir[9]  = mk(1, 0, 3'b001, 32'h103, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0, 32'h0);
        dir[10] = mk(1, 0, 3'b011, 32'h108, 32'h0,         32'h0123_4567, 0, 0, 4'b1111, 32'h0, 32'h0123_4567);
        dir[11] = mk(1, 0, 3'b110, 32'h10A, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0, 32'h0);
        dir[12] = mk(1, 0, 3'b000, 32'h101, 32'h0,         32'h0000_7F00, 0, 0, 4'b0010, 32'h0, 32'h0000_007F);
        dir[13] = mk(0, 1, 3'b010, 32'h206, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst.m_req", 32'(m_req), 32'd0);
        check("rst.m_we", 32'(m_we), 32'd0);
        check("rst.m_be", 32'(m_be), 32'd0);
        check("rst.m_addr", m_addr, 32'd0);
        check("rst.m_wdata", m_wdata, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.bus_error", 32'(bus_error), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_txn(dir[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(1, 3));
            rv.rd = k[0]; rv.wr = k[1];
            rv.f3 = 3'($urandom_range(0, 7));
            rv.addr = $urandom; rv.wdata = $urandom; rv.mword = $urandom;
            rv.ack_dly = int'($urandom_range(0, 4));
            rv = ref_model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Request presented during DONE must be ignored.
        run_txn(dir[0], "done_ign");
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h700;
        #1;
        check("done_ign.stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("done_ign.m_req", 32'(m_req), 32'd0);
        mem_read = 1'b0;

        // Ack timeout: m_req held for the full window, then a single bus_error pulse.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        mem_read = 1'b0;
        n_req = 0;
        while (m_req === 1'b1 && n_req < 400) begin
            n_req++;
            @(negedge clk);
        end
        check("timeout.len", 32'(n_req), 32'd256);
        check("timeout.bus_error", 32'(bus_error), 32'd1);
        check("timeout.stall", 32'(stall), 32'd0);
        check("timeout.rdata", rdata, 32'd0);
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        check("timeout.pulse_end", 32'(bus_error), 32'd0);
        check("timeout.idle_m_req", 32'(m_req), 32'd0);
        check("timeout.idle_rdata", rdata, 32'd0);

        // Reset in the middle of a stalled load.
        run_txn(dir[0], "pre_rst");
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h800;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid.m_req_T3", 32'(m_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid.m_req", 32'(m_req), 32'd0);
        check("rstmid.stall", 32'(stall), 32'd0);
        check("rstmid.bus_error", 32'(bus_error), 32'd0);
        check("rstmid.rdata", rdata, 32'd0);
        check("rstmid.m_be", 32'(m_be), 32'd0);
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        check("rstmid.late_ack_m_req", 32'(m_req), 32'd0);
        check("rstmid.late_ack_rdata", rdata, 32'd0);
        check("rstmid.late_ack_stall", 32'(stall), 32'd0);
        check("rstmid.late_ack_bus_error", 32'(bus_error), 32'd0);
        run_txn(dir[5], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
